// File: rtl/prom_mem_bridge.sv
// -----------------------------------------------------------------------------
// prom_mem_bridge
//
// Connects the PicoRV32 native memory bus to a 1024x32 Gowin pROM that holds
// the boot firmware. The pROM reads synchronously in bypass mode. Data is
// captured on the edge that ends the single rom_ce cycle and is held until the
// next enabled edge.
//
// A read that hits the ROM window latches the word address and pulses rom_ce
// for one cycle. It then waits WAIT_STATES cycles and returns the pROM output
// with a one-cycle mem_ready. A write into the window is acknowledged with
// zero data and otherwise dropped. Each such write bumps a saturating counter.
// mem_rdata is forced to zero outside the response cycle, so the read bus can
// be OR-combined with other slaves.
//
// Ports
//   clk, resetn          system clock, asynchronous active-low reset
//   mem_valid/instr/addr/wstrb   CPU request (mem_instr is informational)
//   mem_ready, mem_rdata CPU response (one-cycle strobe, data zero otherwise)
//   sel                  combinational window hit (gated by mem_valid)
//   rom_ce, rom_oce      pROM clock enable (one pulse per read), output enable
//   rom_reset            pROM synchronous reset, follows ~resetn
//   rom_ad               registered pROM word address
//   rom_dout             pROM read data
//   wr_viol_cnt          saturating count of dropped writes
// -----------------------------------------------------------------------------
module prom_mem_bridge #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              sel,
    output logic              rom_ce,
    output logic              rom_oce,
    output logic              rom_reset,
    output logic [ADDR_W-1:0] rom_ad,
    input  logic [31:0]       rom_dout,
    output logic [7:0]        wr_viol_cnt
);

    localparam int TAG_LSB = ADDR_W + 2;

    // With WAIT_STATES == 0 the FSM skips WAIT entirely, so WAIT_LAST only
    // has meaning when HAS_WAIT is set.
    localparam bit       HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0] WAIT_LAST = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROM,
        S_WAIT,
        S_RESP
    } state_e;

    state_e              state_q;
    logic                ready_q;
    logic                wr_q;
    logic                rom_ce_q;
    logic [ADDR_W-1:0]   rom_ad_q;
    logic [3:0]          wait_cnt_q;
    logic [7:0]          wr_cnt_q;
    logic [7:0]          wr_cnt_d;

    // Byte-lane bits and the fetch flag play no part in decode.
    logic unused_ok;
    assign unused_ok = &{1'b0, mem_instr, mem_addr[1:0]};

    assign sel = mem_valid && (mem_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);

    always_comb begin
        wr_cnt_d = (wr_cnt_q == 8'hFF) ? wr_cnt_q : wr_cnt_q + 8'd1;
    end

    // NOTE: every control register has an asynchronous reset, so an abort by
    // resetn clears the FSM and rom_ce immediately, without waiting for an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            ready_q    <= 1'b0;
            wr_q       <= 1'b0;
            rom_ce_q   <= 1'b0;
            rom_ad_q   <= '0;
            wait_cnt_q <= 4'd0;
            wr_cnt_q   <= 8'd0;
        end else begin
            // NOTE: the pulse outputs default low here. Each one is then set
            // only on the transition into the state that owns it, so that it
            // stays registered and lasts exactly one cycle.
            ready_q  <= 1'b0;
            rom_ce_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (sel) begin
                        if (mem_wstrb == 4'b0000) begin
                            rom_ad_q <= mem_addr[ADDR_W+1:2];
                            rom_ce_q <= 1'b1;
                            wr_q     <= 1'b0;
                            state_q  <= S_ROM;
                        end else begin
                            wr_q     <= 1'b1;
                            ready_q  <= 1'b1;
                            wr_cnt_q <= wr_cnt_d;
                            state_q  <= S_RESP;
                        end
                    end
                end
                S_ROM: begin
                    if (!mem_valid) begin
                        state_q <= S_IDLE;
                    end else if (HAS_WAIT) begin
                        wait_cnt_q <= 4'd0;
                        state_q    <= S_WAIT;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (!mem_valid) begin
                        wait_cnt_q <= 4'd0;
                        state_q    <= S_IDLE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_q <= 4'd0;
                        ready_q    <= 1'b1;
                        state_q    <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_ready   = ready_q;
    // The pROM output has been holding since the edge that ended ROM.
    assign mem_rdata   = (ready_q && !wr_q) ? rom_dout : 32'h0000_0000;
    assign rom_ce      = rom_ce_q;
    assign rom_ad      = rom_ad_q;
    assign rom_oce     = 1'b1;
    assign rom_reset   = ~resetn;
    assign wr_viol_cnt = wr_cnt_q;

endmodule

// File: tb/tb_prom_mem_bridge.sv
// -----------------------------------------------------------------------------
// tb_prom_mem_bridge
//
// Runs two bridges side by side: WAIT_STATES = 0 (dut0) and WAIT_STATES = 3
// (dut1). Both use a 4 KiB window at address 0. A behavioural pROM drives
// rom_dout for each bridge.
//
// The transaction-level model works out three things for each request:
//   - the cycle in which rom_ce must pulse,
//   - the cycle in which mem_ready must strobe,
//   - the data that must appear at that strobe.
// A negedge process compares every output of both bridges against the model
// on every cycle. Directed sequences add literal expectations on data,
// latency, address and counters.
// -----------------------------------------------------------------------------
module tb_prom_mem_bridge;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;

    logic        mem_valid [2];
    logic        mem_instr [2];
    logic [31:0] mem_addr  [2];
    logic [3:0]  mem_wstrb [2];
    logic        mem_ready [2];
    logic [31:0] mem_rdata [2];
    logic        sel       [2];
    logic        rom_ce    [2];
    logic        rom_oce   [2];
    logic        rom_reset [2];
    logic [9:0]  rom_ad    [2];
    logic [31:0] rom_dout  [2];
    logic [7:0]  wr_viol_cnt [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model state. The stimulus owns the request schedule; the compare
    // process owns the state that evolves with time.
    int          ws [2]        = '{0, 3};
    int          ce_at [2]     = '{-1, -1};
    int          ready_at [2]  = '{-1, -1};
    logic [31:0] rdata_exp [2] = '{32'h0, 32'h0};
    bit          wr_exp [2]    = '{1'b0, 1'b0};
    logic [9:0]  ad_pend [2]   = '{10'h0, 10'h0};
    int          cnt_exp [2];
    logic [9:0]  ad_exp [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    prom_mem_bridge #(.BASE_ADDR(32'h0), .ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]),
        .mem_addr(mem_addr[0]), .mem_wstrb(mem_wstrb[0]),
        .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]), .sel(sel[0]),
        .rom_ce(rom_ce[0]), .rom_oce(rom_oce[0]), .rom_reset(rom_reset[0]),
        .rom_ad(rom_ad[0]), .rom_dout(rom_dout[0]), .wr_viol_cnt(wr_viol_cnt[0])
    );

    prom_mem_bridge #(.BASE_ADDR(32'h0), .ADDR_W(10), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]),
        .mem_addr(mem_addr[1]), .mem_wstrb(mem_wstrb[1]),
        .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]), .sel(sel[1]),
        .rom_ce(rom_ce[1]), .rom_oce(rom_oce[1]), .rom_reset(rom_reset[1]),
        .rom_ad(rom_ad[1]), .rom_dout(rom_dout[1]), .wr_viol_cnt(wr_viol_cnt[1])
    );

    // Firmware image: the first two words are the real boot code; the rest
    // carry their own index so misaddressing is visible.
    function automatic logic [31:0] img_word(input int i);
        if (i == 0) return 32'h14C0_006F;
        if (i == 1) return 32'h0000_0013;
        return {16'hC0DE, 6'd0, 10'(i)};
    endfunction

    function automatic bit hit(input logic [31:0] a);
        return a < 32'h0000_1000;
    endfunction

    // Behavioural pROM in bypass mode.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rom_reset[d])   rom_dout[d] <= 32'h0;
            else if (rom_ce[d]) rom_dout[d] <= img_word(int'(rom_ad[d]));
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit exp_rdy;
        bit exp_ce;
        for (int d = 0; d < 2; d++) begin
            if (!resetn) begin
                cnt_exp[d] = 0;
                ad_exp[d]  = 10'h0;
            end
            exp_ce  = resetn && (cyc == ce_at[d]);
            exp_rdy = resetn && (cyc == ready_at[d]);
            if (exp_ce) ad_exp[d] = ad_pend[d];
            if (exp_rdy && wr_exp[d] && cnt_exp[d] < 255) cnt_exp[d]++;
            check($sformatf("dut%0d sel", d), 32'(sel[d]), 32'(mem_valid[d] && hit(mem_addr[d])));
            check($sformatf("dut%0d mem_ready", d), 32'(mem_ready[d]), 32'(exp_rdy));
            check($sformatf("dut%0d mem_rdata", d), mem_rdata[d],
                  (exp_rdy && !wr_exp[d]) ? rdata_exp[d] : 32'h0);
            check($sformatf("dut%0d rom_ce", d), 32'(rom_ce[d]), 32'(exp_ce));
            check($sformatf("dut%0d rom_ad", d), 32'(rom_ad[d]), 32'(ad_exp[d]));
            check($sformatf("dut%0d wr_viol_cnt", d), 32'(wr_viol_cnt[d]), 32'(cnt_exp[d]));
            check($sformatf("dut%0d rom_oce", d), 32'(rom_oce[d]), 32'd1);
            check($sformatf("dut%0d rom_reset", d), 32'(rom_reset[d]), 32'(!resetn));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a request in the current cycle and schedule its response.
    task automatic issue(input int d, input logic [31:0] a, input logic [3:0] s);
        mem_valid[d] = 1'b1;
        mem_addr[d]  = a;
        mem_wstrb[d] = s;
        if (hit(a)) begin
            if (s == 4'b0000) begin
                ce_at[d]     = cyc + 1;
                ready_at[d]  = cyc + 2 + ws[d];
                rdata_exp[d] = img_word(int'(a[11:2]));
                ad_pend[d]   = a[11:2];
                wr_exp[d]    = 1'b0;
            end else begin
                ce_at[d]     = -1;
                ready_at[d]  = cyc + 1;
                rdata_exp[d] = 32'h0;
                wr_exp[d]    = 1'b1;
            end
        end
    endtask

    task automatic wait_ready(input int d, output int rc);
        rc = -1;
        for (int i = 0; i < 40; i++) begin
            if (mem_ready[d]) begin
                rc = cyc;
                break;
            end
            step();
        end
        check($sformatf("dut%0d ready_seen", d), 32'(rc >= 0), 32'd1);
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input bit keep,
                           output int rc, output int lat, output logic [31:0] data);
        int c;
        c = cyc;
        issue(d, a, 4'b0000);
        wait_ready(d, rc);
        lat  = rc - c;
        data = mem_rdata[d];
        step();
        if (!keep) mem_valid[d] = 1'b0;
    endtask

    task automatic do_write(input int d, input logic [31:0] a, output int lat, output logic [31:0] data);
        int c;
        int rc;
        c = cyc;
        issue(d, a, 4'hF);
        wait_ready(d, rc);
        lat  = rc - c;
        data = mem_rdata[d];
        step();
        mem_valid[d] = 1'b0;
        mem_wstrb[d] = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rc, rc1, lat;
        logic [31:0] data;

        for (int d = 0; d < 2; d++) begin
            mem_valid[d] = 1'b0;
            mem_instr[d] = 1'b0;
            mem_addr[d]  = 32'h0;
            mem_wstrb[d] = 4'b0000;
        end
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        step();
        check("reset mem_ready", 32'(mem_ready[0]), 32'd0);
        check("reset rom_ad", 32'(rom_ad[0]), 32'd0);

        // Boot word fetch.
        mem_instr[0] = 1'b1;
        do_read(0, 32'h0000_0000, 1'b0, rc, lat, data);
        mem_instr[0] = 1'b0;
        check("word0 latency", 32'(lat), 32'd2);
        check("word0 data", data, 32'h14C0_006F);
        step();

        // Back-to-back reads with mem_valid held high.
        do_read(0, 32'h0000_0004, 1'b1, rc1, lat, data);
        check("word1 data", data, 32'h0000_0013);
        do_read(0, 32'h0000_0008, 1'b0, rc, lat, data);
        check("word2 data", data, 32'hC0DE_0002);
        check("b2b spacing", 32'(rc - rc1), 32'd3);
        step();

        // Wait states. The address moves mid-transaction and must be ignored.
        rc1 = cyc;
        issue(1, 32'h0000_0000, 4'b0000);
        step();
        step();
        mem_addr[1] = 32'h0000_0020;
        wait_ready(1, rc);
        check("ws3 latency", 32'(rc - rc1), 32'd5);
        check("ws3 data", mem_rdata[1], 32'h14C0_006F);
        check("ws3 rom_ad latched", 32'(rom_ad[1]), 32'd0);
        step();
        mem_valid[1] = 1'b0;
        step();

        // Abort in ROM (dut0): no response, address stays latched.
        issue(0, 32'h0000_0040, 4'b0000);
        step();
        mem_valid[0] = 1'b0;
        ready_at[0]  = -1;
        repeat (3) step();
        check("abort rom_ad", 32'(rom_ad[0]), 32'h10);

        // Abort in WAIT (dut1), then a clean read.
        issue(1, 32'h0000_0008, 4'b0000);
        repeat (3) step();
        mem_valid[1] = 1'b0;
        ready_at[1]  = -1;
        repeat (2) step();
        do_read(1, 32'h0000_0008, 1'b0, rc, lat, data);
        check("post-abort ws3 latency", 32'(lat), 32'd5);
        check("post-abort ws3 data", data, 32'hC0DE_0002);
        step();

        // First address past the window, then the top word inside it.
        mem_valid[0] = 1'b1;
        mem_addr[0]  = 32'h0000_1000;
        repeat (4) step();
        check("miss sel", 32'(sel[0]), 32'd0);
        mem_valid[0] = 1'b0;
        step();
        do_read(0, 32'h0000_0FFC, 1'b0, rc, lat, data);
        check("top latency", 32'(lat), 32'd2);
        check("top data", data, 32'hC0DE_03FF);
        check("top rom_ad", 32'(rom_ad[0]), 32'h3FF);
        step();

        // Dropped writes (the write data 0xDEADBEEF never reaches this bridge).
        do_write(0, 32'h0000_0010, lat, data);
        check("write latency", 32'(lat), 32'd1);
        check("write rdata", data, 32'h0);
        check("write count 1", 32'(wr_viol_cnt[0]), 32'd1);
        for (int i = 0; i < 299; i++) begin
            do_write(0, 32'h0000_0010 + 32'(4 * (i % 8)), lat, data);
        end
        step();
        check("write count saturated", 32'(wr_viol_cnt[0]), 32'd255);

        // Asynchronous reset during ROM.
        issue(0, 32'h0000_0000, 4'b0000);
        step();
        #1;
        resetn = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ce_at[d]    = -1;
            ready_at[d] = -1;
        end
        mem_valid[0] = 1'b0;
        #1;
        check("rst rom_ce", 32'(rom_ce[0]), 32'd0);
        check("rst mem_ready", 32'(mem_ready[0]), 32'd0);
        check("rst rom_reset", 32'(rom_reset[0]), 32'd1);
        check("rst wr_viol_cnt", 32'(wr_viol_cnt[0]), 32'd0);
        @(posedge clk);
        #3 resetn = 1'b1;
        step();
        do_read(0, 32'h0000_0000, 1'b0, rc, lat, data);
        check("post-reset latency", 32'(lat), 32'd2);
        check("post-reset data", data, 32'h14C0_006F);
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
